// File: rtl/pulse_gen_pkg.sv
// Shared definitions for the pulse train generator.
//   state_e    : FSM state encoding (IDLE, HIGH, LOW, DONE)
//   DEF_CNT_W  : default width of the high/low length fields
//   DEF_NUM_W  : default width of the pulse-count field
package pulse_gen_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HIGH = 2'd1,
      ST_LOW  = 2'd2,
      ST_DONE = 2'd3
   } state_e;

   localparam int DEF_CNT_W = 16;
   localparam int DEF_NUM_W = 8;

endpackage

// File: rtl/pulse_len_cnt.sv
// Loadable down counter with a zero flag, for phase timing.
//   clk_i      : clock, rising edge
//   rst_ni     : synchronous active-low reset, clears the count
//   load_i     : load load_val_i this edge (takes priority over counting)
//   load_val_i : value to load, i.e. phase length minus one
//   zero_o     : count currently reads zero
// The count saturates at zero, so an idle counter never wraps.
module pulse_len_cnt #(
   parameter int CNT_W = 16
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             load_i,
   input  logic [CNT_W-1:0] load_val_i,
   output logic             zero_o
);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/pulse_train_gen.sv
// Generates N pulses of H cycles high separated by L cycles low after a
// one-cycle start strobe; flags completion with the last falling edge.
//   I_clk       : clock, rising edge
//   I_rst_n     : synchronous active-low reset
//   I_start     : start strobe, accepted only in IDLE
//   I_stop      : synchronous abort, priority over start
//   I_highLen   : high width in cycles (0 treated as 1), sampled on start
//   I_lowLen    : low gap in cycles (0 treated as 1), sampled on start
//   I_pulseNum  : number of pulses, sampled on start
//   O_sig       : pulse train
//   O_busy      : high in HIGH, LOW and DONE
//   O_done      : one-cycle completion flag
//   O_pulseIdx  : completed pulses in the current train
//
// state | meaning
// IDLE  | waiting for start, O_sig low
// HIGH  | driving a pulse for H cycles
// LOW   | gap of L cycles between pulses
// DONE  | one cycle with O_done high, then back to IDLE
module pulse_train_gen
   import pulse_gen_pkg::*;
#(
   parameter int CNT_W = DEF_CNT_W,
   parameter int NUM_W = DEF_NUM_W
) (
   input  logic             I_clk,
   input  logic             I_rst_n,
   input  logic             I_start,
   input  logic             I_stop,
   input  logic [CNT_W-1:0] I_highLen,
   input  logic [CNT_W-1:0] I_lowLen,
   input  logic [NUM_W-1:0] I_pulseNum,
   output logic             O_sig,
   output logic             O_busy,
   output logic             O_done,
   output logic [NUM_W-1:0] O_pulseIdx
);

   state_e           state_q, state_d;
   logic             sig_q, sig_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [NUM_W-1:0] idx_q, idx_d;
   logic [NUM_W-1:0] num_q, num_d;
   logic [CNT_W-1:0] high_q, high_d;
   logic [CNT_W-1:0] low_q, low_d;

   logic             cnt_load;
   logic [CNT_W-1:0] cnt_val;
   logic             cnt_zero;
   logic [CNT_W-1:0] start_high;
   logic [CNT_W-1:0] start_low;
   logic [NUM_W-1:0] idx_inc;

   assign start_high = (I_highLen == '0) ? CNT_W'(1) : I_highLen;
   assign start_low  = (I_lowLen  == '0) ? CNT_W'(1) : I_lowLen;
   assign idx_inc    = idx_q + NUM_W'(1);

   pulse_len_cnt #(.CNT_W(CNT_W)) u_len_cnt (
      .clk_i      (I_clk),
      .rst_ni     (I_rst_n),
      .load_i     (cnt_load),
      .load_val_i (cnt_val),
      .zero_o     (cnt_zero)
   );

   always_comb begin
      state_d  = state_q;
      sig_d    = sig_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      idx_d    = idx_q;
      num_d    = num_q;
      high_d   = high_q;
      low_d    = low_q;
      cnt_load = 1'b0;
      cnt_val  = high_q - CNT_W'(1);

      if (I_stop) begin
         state_d = ST_IDLE;
         sig_d   = 1'b0;
         busy_d  = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               sig_d  = 1'b0;
               busy_d = 1'b0;
               if (I_start) begin
                  high_d = start_high;
                  low_d  = start_low;
                  num_d  = I_pulseNum;
                  idx_d  = '0;
                  busy_d = 1'b1;
                  if (I_pulseNum == '0) begin
                     state_d = ST_DONE;
                     done_d  = 1'b1;
                  end else begin
                     state_d  = ST_HIGH;
                     sig_d    = 1'b1;
                     cnt_load = 1'b1;
                     cnt_val  = start_high - CNT_W'(1);
                  end
               end
            end
            ST_HIGH: begin
               if (cnt_zero) begin
                  idx_d = idx_inc;
                  sig_d = 1'b0;
                  if (idx_inc == num_q) begin
                     state_d = ST_DONE;
                     done_d  = 1'b1;
                  end else begin
                     state_d  = ST_LOW;
                     cnt_load = 1'b1;
                     cnt_val  = low_q - CNT_W'(1);
                  end
               end
            end
            ST_LOW: begin
               if (cnt_zero) begin
                  state_d  = ST_HIGH;
                  sig_d    = 1'b1;
                  cnt_load = 1'b1;
                  cnt_val  = high_q - CNT_W'(1);
               end
            end
            ST_DONE: begin
               state_d = ST_IDLE;
               busy_d  = 1'b0;
            end
            default: begin
               state_d = ST_IDLE;
               sig_d   = 1'b0;
               busy_d  = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge I_clk) begin
      if (!I_rst_n) begin
         state_q <= ST_IDLE;
         sig_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         idx_q   <= '0;
         num_q   <= '0;
         high_q  <= '0;
         low_q   <= '0;
      end else begin
         state_q <= state_d;
         sig_q   <= sig_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         idx_q   <= idx_d;
         num_q   <= num_d;
         high_q  <= high_d;
         low_q   <= low_d;
      end
   end

   assign O_sig      = sig_q;
   assign O_busy     = busy_q;
   assign O_done     = done_q;
   assign O_pulseIdx = idx_q;

endmodule

// File: tb/tb_pulse_train_gen.sv
// Directed bench for pulse_train_gen. Expected per-cycle outputs are pushed
// to a scoreboard queue when stimulus is driven and popped one per cycle.
module tb_pulse_train_gen;

   localparam int CNT_W = 16;
   localparam int NUM_W = 8;

   typedef struct {
      logic       sig;
      logic       busy;
      logic       done;
      logic [7:0] idx;
   } exp_t;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             start = 1'b0;
   logic             stop = 1'b0;
   logic [CNT_W-1:0] high_len = '0;
   logic [CNT_W-1:0] low_len = '0;
   logic [NUM_W-1:0] pulse_num = '0;
   logic             sig;
   logic             busy;
   logic             done;
   logic [NUM_W-1:0] idx;

   exp_t sb[$];
   int   n_pass = 0;
   int   n_total = 0;
   int   fall_cnt = 0;
   logic prev_sig = 1'b0;

   always #5 clk = ~clk;

   pulse_train_gen #(.CNT_W(CNT_W), .NUM_W(NUM_W)) dut (
      .I_clk      (clk),
      .I_rst_n    (rst_n),
      .I_start    (start),
      .I_stop     (stop),
      .I_highLen  (high_len),
      .I_lowLen   (low_len),
      .I_pulseNum (pulse_num),
      .O_sig      (sig),
      .O_busy     (busy),
      .O_done     (done),
      .O_pulseIdx (idx)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_total++;
      assert (obs === exp_v) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
   endtask

   task automatic push_exp(input logic s, input logic b, input logic d, input logic [7:0] i);
      exp_t e;
      e.sig  = s;
      e.busy = b;
      e.done = d;
      e.idx  = i;
      sb.push_back(e);
   endtask

   task automatic push_idle(input int n, input logic [7:0] i);
      for (int k = 0; k < n; k++) push_exp(1'b0, 1'b0, 1'b0, i);
   endtask

   // Reference train: cycle t=1 is the first cycle after the start edge.
   task automatic push_train(input int h, input int l, input int n);
      int   he, le, dt, ni;
      logic s;
      he = (h == 0) ? 1 : h;
      le = (l == 0) ? 1 : l;
      dt = (n == 0) ? 1 : 1 + n * he + (n - 1) * le;
      for (int t = 1; t <= dt; t++) begin
         ni = 0;
         for (int i = 0; i < n; i++) if (1 + i * (he + le) + he <= t) ni++;
         s = (n > 0) && (((t - 1) / (he + le)) < n) && (((t - 1) % (he + le)) < he);
         push_exp(s, 1'b1, (t == dt), 8'(ni));
      end
   endtask

   task automatic step(input string tag);
      exp_t e;
      @(posedge clk);
      @(negedge clk);
      if (prev_sig && !sig) fall_cnt++;
      prev_sig = sig;
      if (sb.size() == 0) begin
         check({tag, "_sb_empty"}, 32'd1, 32'd0);
      end else begin
         e = sb.pop_front();
         check({tag, "_sig"},  32'(sig),  32'(e.sig));
         check({tag, "_busy"}, 32'(busy), 32'(e.busy));
         check({tag, "_done"}, 32'(done), 32'(e.done));
         check({tag, "_idx"},  32'(idx),  32'(e.idx));
      end
   endtask

   task automatic drain(input string tag);
      int guard;
      guard = 0;
      while (sb.size() > 0 && guard < 70000) begin
         step(tag);
         guard++;
      end
      check({tag, "_drain_budget"}, 32'(sb.size()), 32'd0);
   endtask

   task automatic start_train(input string tag, input int h, input int l, input int n);
      high_len  = CNT_W'(h);
      low_len   = CNT_W'(l);
      pulse_num = NUM_W'(n);
      push_train(h, l, n);
      start = 1'b1;
      step(tag);
      start = 1'b0;
   endtask

   initial begin
      // Reset held with start asserted: nothing may be accepted.
      rst_n = 1'b0;
      start = 1'b1;
      high_len = 16'd3;
      pulse_num = 8'd2;
      push_idle(3, 8'd0);
      step("rst");
      step("rst");
      step("rst");
      start = 1'b0;
      rst_n = 1'b1;
      push_idle(3, 8'd0);
      drain("post_rst");

      // H=3, L=2, N=3 with falling-edge counting.
      fall_cnt = 0;
      start_train("t2", 3, 2, 3);
      push_idle(2, 8'd3);
      drain("t2");
      check("t2_falls", 32'(fall_cnt), 32'd3);

      // Zero lengths behave as one cycle.
      start_train("t3", 0, 0, 2);
      push_idle(2, 8'd2);
      drain("t3");

      // Zero pulses: straight to DONE.
      start_train("t4", 5, 5, 0);
      push_idle(2, 8'd0);
      drain("t4");

      // Restart strobe mid-train is ignored.
      fall_cnt = 0;
      start_train("t5a", 3, 2, 3);
      for (int k = 0; k < 5; k++) step("t5a");
      high_len  = 16'd1;
      low_len   = 16'd1;
      pulse_num = 8'd1;
      start = 1'b1;
      step("t5a_restart");
      start = 1'b0;
      push_idle(2, 8'd3);
      drain("t5a");
      check("t5a_falls", 32'(fall_cnt), 32'd3);

      // Abort in the first gap.
      start_train("t5b", 3, 2, 3);
      step("t5b");
      step("t5b");
      step("t5b");
      sb.delete();
      push_idle(4, 8'd1);
      stop = 1'b1;
      step("t5b_stop");
      stop = 1'b0;
      drain("t5b_stop");

      // Stop wins over start on the same edge.
      high_len  = 16'd2;
      pulse_num = 8'd2;
      push_idle(2, 8'd1);
      start = 1'b1;
      stop  = 1'b1;
      step("stop_prio");
      start = 1'b0;
      stop  = 1'b0;
      drain("stop_prio");

      // Reset mid-train.
      start_train("rst_mid", 2, 2, 4);
      step("rst_mid");
      step("rst_mid");
      sb.delete();
      push_idle(2, 8'd0);
      rst_n = 1'b0;
      step("rst_mid_rst");
      rst_n = 1'b1;
      drain("rst_mid");

      // Maximum high width without wrap.
      start_train("t6", 65535, 0, 1);
      push_idle(2, 8'd1);
      drain("t6");

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
